// File: rtl/amoa_pkg.sv
// Shared A-MOA definitions: serializer FSM states and the per-column error triple,
// used by the RTL column generator and by reference models.
package amoa_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int ERR_W = 3;

    // One ones -> 000, two -> 001, three -> 110, so a+b+c == apx + popcount(err).
    function automatic logic [ERR_W-1:0] err_triple(input logic a, input logic b, input logic c);
        logic t;
        logic m;
        t = a & b & c;
        m = (a & b) | (a & c) | (b & c);
        return {t, t, m & ~t};
    endfunction

endpackage

// File: rtl/ec_col_gen.sv
// Combinational column generator: per column, approximate OR-sum bit and error triple.
module ec_col_gen
    import amoa_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]            a_i,
    input  logic [W-1:0]            b_i,
    input  logic [W-1:0]            c_i,
    output logic [W-1:0]            apx_o,
    output logic [W-1:0][ERR_W-1:0] err_o
);

    for (genvar i = 0; i < W; i++) begin : g_col
        assign apx_o[i] = a_i[i] | b_i[i] | c_i[i];
        assign err_o[i] = err_triple(a_i[i], b_i[i], c_i[i]);
    end

endmodule

// File: rtl/ec_err_serializer.sv
// EC chain producer: latches a frame of three W-bit operand columns and streams one
// {err, apx} beat per column, LSB first, with zero-bubble back-to-back frames.
module ec_err_serializer
    import amoa_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    input  logic [W-1:0]     op_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ERR_W-1:0] err_out,
    output logic             apx_bit,
    output logic [CNT_W-1:0] col_idx,
    output logic             last,
    output logic [CNT_W-1:0] err_cols
);

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(W - 2);

    state_t                  state_q;
    logic [W-1:0]            a_q, b_q, c_q;
    logic                    vld_q;
    logic                    last_q;
    logic [CNT_W-1:0]        col_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        err_cols_q;
    logic [W-1:0]            apx_vec;
    logic [W-1:0][ERR_W-1:0] err_vec;
    logic                    beat, in_hs, beat_err;
    logic                    unused_cols;

    ec_col_gen #(.W(W)) u_col_gen (
        .a_i   (a_q),
        .b_i   (b_q),
        .c_i   (c_q),
        .apx_o (apx_vec),
        .err_o (err_vec)
    );

    // Operands shift right per beat, so the current column always sits at bit 0.
    assign unused_cols = ^{apx_vec[W-1:1], err_vec[W-1:1]};
    assign beat        = vld_q & out_ready;
    assign in_ready    = (state_q == IDLE) | (beat & last_q);
    assign in_hs       = in_valid & in_ready;
    assign beat_err    = |err_vec[0];
    assign cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, beat_err};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            vld_q      <= 1'b0;
            last_q     <= 1'b0;
            col_q      <= '0;
            cnt_q      <= '0;
            err_cols_q <= '0;
        end else begin
            if (beat) begin
                a_q <= a_q >> 1;
                b_q <= b_q >> 1;
                c_q <= c_q >> 1;
            end
            if (beat && last_q) err_cols_q <= cnt_d;
            if (in_hs) begin
                state_q <= STREAM;
                a_q     <= op_a;
                b_q     <= op_b;
                c_q     <= op_c;
                vld_q   <= 1'b1;
                last_q  <= 1'b0;
                col_q   <= '0;
                cnt_q   <= '0;
            end else if (beat) begin
                if (last_q) begin
                    state_q <= IDLE;
                    vld_q   <= 1'b0;
                    last_q  <= 1'b0;
                    col_q   <= '0;
                end else begin
                    col_q  <= col_q + 1'b1;
                    last_q <= (col_q == PRE_LAST);
                    cnt_q  <= cnt_d;
                end
            end
        end
    end

    assign out_valid = vld_q;
    assign err_out   = err_vec[0];
    assign apx_bit   = apx_vec[0];
    assign col_idx   = col_q;
    assign last      = last_q;
    assign err_cols  = err_cols_q;

endmodule

// File: tb/tb_ec_err_serializer.sv
// Randomized bench for ec_err_serializer against a column-counting reference model.
module tb_ec_err_serializer;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     op_a = '0, op_b = '0, op_c = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [2:0]       err_out;
    logic             apx_bit;
    logic [CNT_W-1:0] col_idx;
    logic             last;
    logic [CNT_W-1:0] err_cols;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;

    typedef struct {
        logic [2:0] err;
        logic       apx;
        int         idx;
        logic       lst;
        int         ec;
    } beat_t;

    beat_t q[$];
    int    exp_ec = 0;
    bit    ec_pend = 1'b0;
    bit    bub_pend = 1'b0;

    ec_err_serializer #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .out_valid(out_valid), .out_ready(out_ready),
        .err_out(err_out), .apx_bit(apx_bit), .col_idx(col_idx), .last(last), .err_cols(err_cols)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: count ones per column; err/apx follow directly from that count.
    task automatic push_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        beat_t bt;
        int n, ec;
        ec = 0;
        for (int i = 0; i < W; i++) begin
            n = int'(a[i]) + int'(b[i]) + int'(c[i]);
            if (n >= 2) ec++;
        end
        for (int i = 0; i < W; i++) begin
            n = int'(a[i]) + int'(b[i]) + int'(c[i]);
            bt.err = (n == 3) ? 3'b110 : (n == 2) ? 3'b001 : 3'b000;
            bt.apx = (n != 0);
            bt.idx = i;
            bt.lst = (i == W - 1);
            bt.ec  = ec;
            q.push_back(bt);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_ec   = 0;
            ec_pend  = 1'b0;
            bub_pend = 1'b0;
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_outs", {err_out, apx_bit, col_idx, last, err_cols}, 0);
        end else begin
            if (ec_pend) begin
                chk("err_cols", err_cols, exp_ec);
                ec_pend = 1'b0;
            end
            if (bub_pend) begin
                chk("no_bubble", out_valid, 1);
                bub_pend = 1'b0;
            end
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_beat", out_valid, 0);
                else begin
                    chk("err_out", err_out, q[0].err);
                    chk("apx_bit", apx_bit, q[0].apx);
                    chk("col_idx", col_idx, q[0].idx);
                    chk("last", last, q[0].lst);
                    if (out_ready) begin
                        if (q[0].lst) begin
                            exp_ec  = q[0].ec;
                            ec_pend = 1'b1;
                        end
                        void'(q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (out_valid && out_ready) bub_pend = 1'b1;
                push_frame(op_a, op_b, op_c);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        bit done;
        done = 1'b0;
        op_a = a; op_b = b; op_c = c;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q.size() != 0 || ec_pend) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) chk("drain_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_col(input int col);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            seen = out_valid && (int'(col_idx) == col);
        end
        if (!seen) chk("wait_col_timeout", 0, 1);
    endtask

    initial begin
        // Reset with a frame offered: nothing may be captured.
        in_valid = 1'b1;
        op_a = 8'hA5; op_b = 8'h3C; op_c = 8'hFF;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_beat_after_rst", out_valid, 0);
        end

        @(posedge clk); #1;
        send_frame(8'hFF, 8'hFF, 8'hFF);
        drain();
        chk("err_cols_all3", err_cols, 8);

        send_frame(8'h03, 8'h05, 8'h00);
        drain();
        chk("err_cols_one", err_cols, 1);

        // Stall three cycles while col 4 is presented.
        send_frame(8'h5A, 8'hC3, 8'h96);
        wait_col(3);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Back-to-back: second frame accepted on the first frame's last beat.
        send_frame(8'h0F, 8'hF0, 8'hAA);
        send_frame(8'h77, 8'h71, 8'h17);
        drain();

        // Reset mid-frame, then a clean frame.
        send_frame(8'hEE, 8'hDD, 8'hBB);
        wait_col(3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_beat_after_abort", out_valid, 0);
        end
        @(posedge clk); #1;
        send_frame(8'h3C, 8'h0F, 8'hC1);
        drain();

        // Random frames with random backpressure and gaps.
        rdy_mode = 1;
        for (int f = 0; f < 30; f++) begin
            send_frame(W'($urandom), W'($urandom), W'($urandom));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 10)) @(posedge clk);
            #1;
        end
        drain();
        rdy_mode = 0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
